// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - shared types, field positions and helpers for alu_sequencer
package alu_sequencer_pkg;

  localparam int XLEN = 16;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_SLL   = 4'h2,
    ALU_SRL   = 4'h3,
    ALU_SRA   = 4'h4,
    ALU_SLT   = 4'h5,
    ALU_SLTU  = 4'h6,
    ALU_XOR   = 4'h7,
    ALU_OR    = 4'h8,
    ALU_AND   = 4'h9,
    ALU_LUI   = 4'hA,
    ALU_AUIPC = 4'hB
  } alu_op_t;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_SLL    = 4'h2,
    OP_SRL    = 4'h3,
    OP_SRA    = 4'h4,
    OP_SLT    = 4'h5,
    OP_SLTU   = 4'h6,
    OP_XOR    = 4'h7,
    OP_OR     = 4'h8,
    OP_AND    = 4'h9,
    OP_ADDI   = 4'hA,
    OP_LUI    = 4'hB,
    OP_AUIPC  = 4'hC,
    OP_RSVD_D = 4'hD,
    OP_RSVD_E = 4'hE,
    OP_RSVD_F = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK
  } seq_state_t;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int RD_MSB   = 11;
  localparam int RD_LSB   = 9;
  localparam int RS1_MSB  = 8;
  localparam int RS1_LSB  = 6;
  localparam int RS2_MSB  = 5;
  localparam int RS2_LSB  = 3;
  localparam int IMM6_MSB = 5;
  localparam int IMM9_MSB = 8;

  function automatic logic [XLEN-1:0] sext_imm6(input logic [XLEN-1:0] ins);
    return {{(XLEN-IMM6_MSB-1){ins[IMM6_MSB]}}, ins[IMM6_MSB:0]};
  endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// rtl/alu_sequencer_regfile.sv - register file, one sync write port, three comb read ports, r0 = 0
module seq_regfile
  import alu_sequencer_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic [XLEN-1:0] dbg_data
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1   = (raddr1   == '0) ? '0 : regs[raddr1];
  assign rdata2   = (raddr2   == '0) ? '0 : regs[raddr2];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - 4-cycle issue/writeback controller for the 16-bit ALU
// Optional retire/illegal counters under macro ALU_SEQ_STATS_EN.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int             NREGS    = 8,
  parameter logic [XLEN-1:0] PC_RESET = 16'h0000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     instr_valid,
  input  logic [XLEN-1:0]          instr,
  output logic                     instr_ready,
  output alu_op_t                  alu_op,
  output logic [XLEN-1:0]          alu_input1,
  output logic [XLEN-1:0]          alu_input2,
  input  logic [XLEN-1:0]          alu_result,
  output logic                     wb_valid,
  output logic [$clog2(NREGS)-1:0] wb_rd,
  output logic [XLEN-1:0]          wb_data,
  output logic                     illegal_instr,
  output logic [XLEN-1:0]          pc,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [XLEN-1:0]          dbg_data
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]              retired_count,
  output logic [15:0]              illegal_count
`endif
);

  seq_state_t      state, next_state;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] rs1_data, rs2_data;
  opcode_t         opcode;
  logic            dec_legal;
  alu_op_t         dec_op;
  logic [XLEN-1:0] dec_in1, dec_in2;

  assign opcode  = opcode_t'(instr_q[OPC_MSB:OPC_LSB]);
  assign wb_rd   = instr_q[RD_MSB:RD_LSB];
  assign wb_data = result_q;

  seq_regfile #(.NREGS(NREGS)) u_regfile (
    .clock    (clock),
    .reset    (reset),
    .we       (wb_valid),
    .waddr    (wb_rd),
    .wdata    (result_q),
    .raddr1   (instr_q[RS1_MSB:RS1_LSB]),
    .raddr2   (instr_q[RS2_MSB:RS2_LSB]),
    .dbg_addr (dbg_addr),
    .rdata1   (rs1_data),
    .rdata2   (rs2_data),
    .dbg_data (dbg_data)
  );

  always_comb begin
    dec_legal = 1'b1;
    dec_op    = ALU_ADD;
    dec_in1   = rs1_data;
    dec_in2   = rs2_data;
    case (opcode)
      OP_ADD:   dec_op = ALU_ADD;
      OP_SUB:   dec_op = ALU_SUB;
      OP_SLL:   dec_op = ALU_SLL;
      OP_SRL:   dec_op = ALU_SRL;
      OP_SRA:   dec_op = ALU_SRA;
      OP_SLT:   dec_op = ALU_SLT;
      OP_SLTU:  dec_op = ALU_SLTU;
      OP_XOR:   dec_op = ALU_XOR;
      OP_OR:    dec_op = ALU_OR;
      OP_AND:   dec_op = ALU_AND;
      OP_ADDI:  dec_in2 = sext_imm6(instr_q);
      OP_LUI: begin
        dec_op  = ALU_LUI;
        dec_in1 = '0;
        dec_in2 = {instr_q[IMM9_MSB:0], 7'b0};
      end
      OP_AUIPC: begin
        dec_op  = ALU_AUIPC;
        dec_in1 = pc;
        dec_in2 = sext_imm6(instr_q);
      end
      default:  dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    instr_ready   = 1'b0;
    illegal_instr = 1'b0;
    wb_valid      = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) next_state = S_DECODE;
      end
      S_DECODE: begin
        if (dec_legal) begin
          next_state = S_EXECUTE;
        end else begin
          illegal_instr = 1'b1;
          next_state    = S_IDLE;
        end
      end
      S_EXECUTE:   next_state = S_WRITEBACK;
      S_WRITEBACK: begin
        wb_valid   = 1'b1;
        next_state = S_IDLE;
      end
      default:     next_state = S_IDLE;
    endcase
  end

  // ALU operands are held between instructions; only EXECUTE gives them meaning.
  always_ff @(posedge clock) begin
    if (reset) begin
      instr_q    <= '0;
      result_q   <= '0;
      alu_op     <= ALU_ADD;
      alu_input1 <= '0;
      alu_input2 <= '0;
      pc         <= PC_RESET;
    end else begin
      if (instr_ready && instr_valid) instr_q <= instr;
      if (state == S_DECODE && dec_legal) begin
        alu_op     <= dec_op;
        alu_input1 <= dec_in1;
        alu_input2 <= dec_in2;
      end
      if (state == S_EXECUTE) result_q <= alu_result;
      if (wb_valid || illegal_instr) pc <= pc + 16'd1;
    end
  end

`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      retired_count <= '0;
      illegal_count <= '0;
    end else begin
      if (wb_valid)      retired_count <= retired_count + 16'd1;
      if (illegal_instr) illegal_count <= illegal_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer with a behavioural ISA model
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  alu_op_t     alu_op;
  logic [15:0] alu_input1, alu_input2, alu_result;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        illegal_instr;
  logic [15:0] pc;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] retired_count, illegal_count;
`endif

  alu_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_ready   (instr_ready),
    .alu_op        (alu_op),
    .alu_input1    (alu_input1),
    .alu_input2    (alu_input2),
    .alu_result    (alu_result),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .illegal_instr (illegal_instr),
    .pc            (pc),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data)
`ifdef ALU_SEQ_STATS_EN
    ,
    .retired_count (retired_count),
    .illegal_count (illegal_count)
`endif
  );

  always #5 clock = ~clock;

  // The ALU the sequencer drives
  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD, ALU_AUIPC, ALU_LUI: alu_result = alu_input1 + alu_input2;
      ALU_SUB:  alu_result = alu_input1 - alu_input2;
      ALU_SLL:  alu_result = alu_input1 << alu_input2[3:0];
      ALU_SRL:  alu_result = alu_input1 >> alu_input2[3:0];
      ALU_SRA:  alu_result = $signed(alu_input1) >>> alu_input2[3:0];
      ALU_SLT:  alu_result = ($signed(alu_input1) < $signed(alu_input2)) ? 16'd1 : 16'd0;
      ALU_SLTU: alu_result = (alu_input1 < alu_input2) ? 16'd1 : 16'd0;
      ALU_XOR:  alu_result = alu_input1 ^ alu_input2;
      ALU_OR:   alu_result = alu_input1 | alu_input2;
      ALU_AND:  alu_result = alu_input1 & alu_input2;
      default:  alu_result = '0;
    endcase
  end

  typedef struct {
    logic        ill;
    logic [2:0]  rd;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mregs [8];
  logic [15:0] mpc;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    mpc = 16'h0000;
    exp_q.delete();
  endtask

  // ISA-level model: result from instruction fields and architectural state
  task automatic model_push(input logic [15:0] w);
    exp_t        e;
    logic [15:0] a, b, imm, r;
    a   = mregs[w[8:6]];
    b   = mregs[w[5:3]];
    imm = {{10{w[5]}}, w[5:0]};
    r   = '0;
    e.ill = 1'b0;
    e.rd  = w[11:9];
    case (w[15:12])
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a << b[3:0];
      4'h3: r = a >> b[3:0];
      4'h4: r = $signed(a) >>> b[3:0];
      4'h5: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      4'h6: r = (a < b) ? 16'd1 : 16'd0;
      4'h7: r = a ^ b;
      4'h8: r = a | b;
      4'h9: r = a & b;
      4'hA: r = a + imm;
      4'hB: r = {w[8:0], 7'b0};
      4'hC: r = mpc + imm;
      default: e.ill = 1'b1;
    endcase
    e.data = r;
    if (!e.ill && e.rd != 3'd0) mregs[e.rd] = r;
    mpc = mpc + 16'd1;
    exp_q.push_back(e);
  endtask

  always @(negedge clock) begin
    if (!reset && (wb_valid || illegal_instr)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {wb_valid, illegal_instr}, 2'b00);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_illegal", illegal_instr, e.ill);
        check("sb_wb_valid", wb_valid, !e.ill);
        if (!e.ill) begin
          check("sb_wb_rd", wb_rd, e.rd);
          check("sb_wb_data", wb_data, e.data);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clock);
    while (!instr_ready && g < 50) begin
      @(negedge clock);
      g++;
    end
    check("idle_wait", instr_ready, 1'b1);
  endtask

  // Handshake happens on the posedge ending cycle 0; returns 1 time unit after it.
  task automatic issue(input logic [15:0] w, input bit timed);
    int g = 0;
    bit ill;
    @(negedge clock);
    while (!instr_ready && g < 50) begin
      @(negedge clock);
      g++;
    end
    if (!instr_ready) check("ready_timeout", instr_ready, 1'b1);
    instr_valid = 1'b1;
    instr       = w;
    model_push(w);
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    instr       = 16'($urandom);
    ill = (w[15:12] >= 4'hD);
    if (timed) begin
      for (int c = 1; c <= (ill ? 2 : 4); c++) begin
        @(negedge clock);
        instr = 16'($urandom);
        if (ill) begin
          check($sformatf("ill_ready_c%0d", c), instr_ready, c == 2);
          check($sformatf("ill_pulse_c%0d", c), illegal_instr, c == 1);
          check($sformatf("ill_wb_c%0d", c), wb_valid, 1'b0);
        end else begin
          check($sformatf("ready_c%0d", c), instr_ready, c == 4);
          check($sformatf("wb_valid_c%0d", c), wb_valid, c == 3);
        end
      end
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), dbg_data, mregs[i]);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();
    @(negedge clock);
    check("rst_ready", instr_ready, 1'b1);
    check("rst_pc", pc, 16'h0000);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_illegal", illegal_instr, 1'b0);
    check("rst_alu_op", alu_op, ALU_ADD);
    check("rst_in1", alu_input1, 16'h0000);
    check("rst_in2", alu_input2, 16'h0000);
    check("rst_wb_rd", wb_rd, 3'd0);
    check("rst_wb_data", wb_data, 16'h0000);

    issue(16'hA205, 1'b1);
    check("addi_pc", pc, 16'h0001);

    issue(16'hA43F, 1'b0);
    issue(16'h4688, 1'b0);
    @(negedge clock);
    @(negedge clock);
    check("sra_op", alu_op, ALU_SRA);
    check("sra_in1", alu_input1, 16'hFFFF);
    check("sra_in2", alu_input2, 16'h0005);
    wait_idle();
    dbg_addr = 3'd3;
    #1 check("sra_r3", dbg_data, 16'hFFFF);

    issue(16'hB9FF, 1'b0);
    wait_idle();
    dbg_addr = 3'd4;
    #1 check("lui_r4", dbg_data, 16'hFF80);
    while (mpc != 16'h0010) issue({4'($urandom_range(0, 12)), 3'd7, 9'($urandom)}, 1'b0);
    wait_idle();
    check("pc_16", pc, 16'h0010);
    issue(16'hCA02, 1'b0);
    wait_idle();
    dbg_addr = 3'd5;
    #1 check("auipc_r5", dbg_data, 16'h0012);

    issue(16'hE000, 1'b1);
    check("ill_pc", pc, 16'h0012);
    check_regs("ill");

    issue(16'h0048, 1'b0);
    wait_idle();
    dbg_addr = 3'd0;
    #1 check("r0_zero", dbg_data, 16'h0000);

    for (int n = 0; n < 40; n++) issue(16'($urandom), n % 10 == 0);
    wait_idle();
    check("rand_pc", pc, mpc);
    check_regs("rand");

    issue(16'h1C48, 1'b0);
    @(negedge clock);
    @(negedge clock);
    check("abort_in_exec", alu_op, ALU_SUB);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    check("abort_ready", instr_ready, 1'b1);
    repeat (3) begin
      @(negedge clock);
      check("abort_no_wb", wb_valid, 1'b0);
    end
    check("abort_pc", pc, 16'h0000);
    dbg_addr = 3'd6;
    #1 check("abort_r6", dbg_data, 16'h0000);

`ifdef ALU_SEQ_STATS_EN
    issue(16'hA205, 1'b0);
    issue(16'hA43F, 1'b0);
    issue(16'hE000, 1'b0);
    issue(16'h0048, 1'b0);
    wait_idle();
    check("retired_count", retired_count, 16'd3);
    check("illegal_count", illegal_count, 16'd1);
`endif

    wait_idle();
    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
